// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and helpers for the I2S/TDM transmitter
package i2s_pkg;

    typedef enum logic {
        I2S_PHILIPS   = 1'b0,
        I2S_LEFT_JUST = 1'b1
    } i2s_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } tx_state_e;

    // Total serial bits in one frame.
    function automatic int frame_bits(input int channels, input int slot_w);
        return channels * slot_w;
    endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// rtl/i2s_frame_timer.sv - frame position counter, word select and run/stop sequencing
module i2s_frame_timer
    import i2s_pkg::*;
#(
    parameter int F    = 32,
    parameter int MODE = 0
) (
    input  logic sclk_i,
    input  logic rst_i,
    input  logic enable_i,
    output logic load_o,
    output logic ws_o,
    output logic busy_o
);

    localparam i2s_mode_e MODE_E = (MODE == 0) ? I2S_PHILIPS : I2S_LEFT_JUST;
    localparam int PW = (F > 1) ? $clog2(F) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(F - 1);
    localparam logic [PW-1:0] P_HALF = PW'(F / 2);
    // Philips framing delays the MSB by one bit after the ws edge.
    localparam logic [PW-1:0] P_LOAD = (MODE_E == I2S_PHILIPS) ? PW'(1) : PW'(0);

    tx_state_e       state;
    logic [PW-1:0]   p;

    // Stream bit 0 of a frame goes out on this edge.
    assign load_o = (state == RUN) && (p == P_LOAD);
    assign busy_o = (state != IDLE);

    // Run/stop sequencing; a frame always runs to its last position before stopping.
    always_ff @(negedge sclk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            p     <= '0;
            ws_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ws_o <= 1'b0;
                    p    <= '0;
                    if (enable_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    ws_o <= (p >= P_HALF);
                    if (p == P_LAST) begin
                        p <= '0;
                        if (!enable_i) begin
                            state <= (MODE_E == I2S_PHILIPS) ? STOP : IDLE;
                        end
                    end else begin
                        p <= p + PW'(1);
                    end
                end
                STOP: begin
                    ws_o  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// rtl/i2s_tdm_tx.sv - I2S/TDM serializer with one-frame holding buffer
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 16,
    parameter int CHANNELS = 2,
    parameter int MODE     = 0
) (
    input  logic                         sclk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [CHANNELS*DATA_W-1:0]   frame_i,
    input  logic                         frame_valid_i,
    output logic                         frame_ready_o,
    output logic                         ws_o,
    output logic                         sdata_o,
    output logic                         underrun_o,
    output logic                         busy_o
);

    localparam int F = frame_bits(CHANNELS, SLOT_W);

    if (DATA_W < 1 || SLOT_W < DATA_W) begin : g_bad_width
        $error("i2s_tdm_tx: SLOT_W must be >= DATA_W >= 1");
    end
    if (CHANNELS < 2 || CHANNELS > 8 || (CHANNELS % 2) != 0) begin : g_bad_channels
        $error("i2s_tdm_tx: CHANNELS must be even and within 2..8");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("i2s_tdm_tx: MODE must be 0 or 1");
    end

    logic                         hold_full;
    logic [CHANNELS*DATA_W-1:0]   hold_q;
    logic [F-1:0]                 padded;
    logic [F-1:0]                 shreg;
    logic                         load;
    logic                         capture;

    assign frame_ready_o = rst_i & ~hold_full;
    assign capture       = frame_valid_i & frame_ready_o;

    i2s_frame_timer #(
        .F    (F),
        .MODE (MODE)
    ) u_timer (
        .sclk_i   (sclk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .load_o   (load),
        .ws_o     (ws_o),
        .busy_o   (busy_o)
    );

    // Lay the buffered channels into slots, channel 0 first, zero-padding after each LSB.
    always_comb begin
        padded = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            padded[F-1-k*SLOT_W -: SLOT_W] = SLOT_W'(hold_q[k*DATA_W +: DATA_W]) << (SLOT_W - DATA_W);
        end
    end

    // Holding buffer: a load empties it unless a new frame is captured on the same edge.
    always_ff @(negedge sclk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_full <= 1'b0;
            hold_q    <= '0;
        end else if (capture) begin
            hold_q    <= frame_i;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Shift register and serial output; an empty buffer at the load point sends silence.
    always_ff @(negedge sclk_i or negedge rst_i) begin
        if (!rst_i) begin
            shreg      <= '0;
            sdata_o    <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= load & ~hold_full;
            if (load) begin
                if (hold_full) begin
                    sdata_o <= padded[F-1];
                    shreg   <= {padded[F-2:0], 1'b0};
                end else begin
                    sdata_o <= 1'b0;
                    shreg   <= '0;
                end
            end else if (busy_o) begin
                sdata_o <= shreg[F-1];
                shreg   <= {shreg[F-2:0], 1'b0};
            end else begin
                sdata_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb/tb_i2s_tdm_tx.sv - scoreboard bench for i2s_tdm_tx over three configurations
module tb_i2s_tdm_tx;

    localparam int HALF = 5;

    logic sclk = 1'b1;
    always #HALF sclk = ~sclk;

    int checks = 0;
    int errors = 0;
    int ndone  = 0;

    task automatic chk(input int cfg, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL cfg%0d %s actual=%0h required=%0h t=%0t", cfg, name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int DW = (g == 1) ? 24 : 16;
        localparam int SW = (g == 1) ? 32 : 16;
        localparam int CH = (g == 2) ? 4 : 2;
        localparam int MD = (g == 1) ? 1 : 0;
        localparam int FW = CH * DW;
        localparam int F  = CH * SW;
        localparam int D  = (MD == 0) ? 1 : 0;
        localparam logic [FW-1:0] F0 = (g == 1) ? FW'(64'h0000_8000_017F_FFFF) :
                                       (g == 2) ? FW'(64'h4444_3333_2222_1111) :
                                                  FW'(64'h0000_0000_1234_A55A);

        logic          rst_n = 1'b0;
        logic          en    = 1'b0;
        logic          valid = 1'b0;
        logic [FW-1:0] frame = '0;
        logic          ready, ws, sd, ur, busy;

        i2s_tdm_tx #(
            .DATA_W   (DW),
            .SLOT_W   (SW),
            .CHANNELS (CH),
            .MODE     (MD)
        ) dut (
            .sclk_i        (sclk),
            .rst_i         (rst_n),
            .enable_i      (en),
            .frame_i       (frame),
            .frame_valid_i (valid),
            .frame_ready_o (ready),
            .ws_o          (ws),
            .sdata_o       (sd),
            .underrun_o    (ur),
            .busy_o        (busy)
        );

        // Accepted frames not yet loaded, with the time of the capturing edge.
        logic [FW-1:0] exp_q[$];
        time           exp_t[$];

        logic          pb = 1'b0;
        logic          infr = 1'b0;
        logic          meu;
        int            q = 0;
        int            mbi;
        logic [F-1:0]  cur_exp = '0;

        // Expected serial stream: stream bit i is held at e[F-1-i].
        function automatic logic [F-1:0] expand(input logic [FW-1:0] fr);
            logic [F-1:0] e;
            e = '0;
            for (int k = 0; k < CH; k++)
                for (int j = 0; j < DW; j++)
                    e[F-1-(k*SW+j)] = fr[k*DW + DW-1-j];
            return e;
        endfunction

        function automatic logic [FW-1:0] rnd_frame();
            logic [FW-1:0] r;
            for (int k = 0; k < CH; k++) r[k*DW +: DW] = DW'($urandom);
            return r;
        endfunction

        // Monitor: outputs seen after an edge belong to the state that was current during that edge.
        always @(posedge sclk) begin
            if (!rst_n || !pb) begin
                chk(g, "quiet_ws", 64'(ws), 64'(0));
                chk(g, "quiet_sdata", 64'(sd), 64'(0));
                chk(g, "quiet_underrun", 64'(ur), 64'(0));
                infr = 1'b0;
                q = 0;
            end else begin
                mbi = (q - D + F) % F;
                chk(g, "ws", 64'(ws), 64'(q >= F / 2));
                if (mbi == 0) begin
                    if (exp_q.size() != 0 && exp_t[0] < $time - HALF) begin
                        cur_exp = expand(exp_q.pop_front());
                        void'(exp_t.pop_front());
                        meu = 1'b0;
                    end else begin
                        cur_exp = '0;
                        meu = 1'b1;
                    end
                    chk(g, "underrun_at_load", 64'(ur), 64'(meu));
                    infr = 1'b1;
                end else begin
                    chk(g, "underrun_other", 64'(ur), 64'(0));
                end
                chk(g, "sdata", 64'(sd), infr ? 64'(cur_exp[F-1-mbi]) : 64'(0));
                if (mbi == F - 1) infr = 1'b0;
                q = (q + 1) % F;
            end
            chk(g, "ready", 64'(ready), 64'(rst_n && (exp_q.size() == 0)));
            pb = busy & rst_n;
        end

        task automatic cyc(input int n);
            repeat (n) begin
                @(negedge sclk);
                #2;
            end
        endtask

        task automatic offer(input logic [FW-1:0] fv);
            logic got;
            logic r;
            got = 1'b0;
            frame = fv;
            valid = 1'b1;
            for (int i = 0; i < 3 * F && !got; i++) begin
                @(posedge sclk);
                r = ready;
                @(negedge sclk);
                if (r) begin
                    exp_q.push_back(fv);
                    exp_t.push_back($time);
                    got = 1'b1;
                end
                #2;
            end
            valid = 1'b0;
            chk(g, "offer_accepted", 64'(got), 64'(1));
        endtask

        task automatic drain();
            for (int i = 0; i < 4 * F && exp_q.size() != 0; i++) cyc(1);
            chk(g, "drained", 64'(exp_q.size()), 64'(0));
        endtask

        task automatic wait_pos(input int target);
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 4 * F && !hit; i++) begin
                @(negedge sclk);
                if (pb && q == target) hit = 1'b1;
            end
            #2;
            chk(g, "position_reached", 64'(hit), 64'(1));
        endtask

        task automatic wait_idle();
            for (int i = 0; i < 3 * F && busy; i++) cyc(1);
            chk(g, "reached_idle", 64'(busy), 64'(0));
        endtask

        initial begin
            logic [FW-1:0] f;
            cyc(3);
            chk(g, "reset_ready", 64'(ready), 64'(0));
            chk(g, "reset_busy", 64'(busy), 64'(0));
            rst_n = 1'b1;
            cyc(1);
            chk(g, "ready_after_reset", 64'(ready), 64'(1));

            // Prefill while idle, then run.
            offer(F0);
            chk(g, "prefill_idle", 64'(busy), 64'(0));
            en = 1'b1;

            // Starve the transmitter for two frames, then offer mid-frame.
            cyc(2 * F + 3);
            for (int k = 0; k < CH; k++) f[k*DW +: DW] = (k % 2 == 0) ? {DW{1'b1}} : DW'(1);
            offer(f);

            // Back-to-back frames under back-pressure.
            offer(rnd_frame());
            offer(rnd_frame());
            drain();

            // Enable dropped mid-frame: the frame completes before idling.
            wait_pos(5);
            en = 1'b0;
            wait_idle();
            cyc(2);

            // Reset mid-frame aborts at once and discards buffered data.
            en = 1'b1;
            offer(rnd_frame());
            wait_pos(10);
            rst_n = 1'b0;
            exp_q.delete();
            exp_t.delete();
            #1;
            chk(g, "abort_ws", 64'(ws), 64'(0));
            chk(g, "abort_sdata", 64'(sd), 64'(0));
            chk(g, "abort_underrun", 64'(ur), 64'(0));
            chk(g, "abort_busy", 64'(busy), 64'(0));
            chk(g, "abort_ready", 64'(ready), 64'(0));
            en = 1'b0;
            cyc(2);
            rst_n = 1'b1;
            cyc(1);

            // Randomized frames, gaps and enable pauses.
            en = 1'b1;
            for (int n = 0; n < 12; n++) begin
                offer(rnd_frame());
                cyc($urandom_range(0, F + F / 2));
                if ($urandom_range(0, 3) == 0) begin
                    en = 1'b0;
                    cyc($urandom_range(1, 2 * F));
                    en = 1'b1;
                end
            end
            drain();
            en = 1'b0;
            wait_idle();
            cyc(2);
            ndone++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && ndone < 3; i++) @(posedge sclk);
        chk(-1, "all_configs_done", 64'(ndone), 64'(3));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
